me_mem_stage: RTL and testbench

ME_MEM_STAGE -- requirements
Module: me_mem_stage

---
 rtl/me_mem_stage_pkg.sv | 33 +++
 rtl/me_load_align.sv | 54 +++++
 rtl/me_mem_stage.sv | 214 +++++++++++++++++++++
 tb/tb_me_mem_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_mem_stage_pkg.sv
// me_mem_stage_pkg -- shared definitions for the memory (ME) pipeline stage.
//
// Contents:
//   - ld_op encodings. Bit 2 selects zero extension; bits 1:0 select the size.
//   - me_state_e: the one-entry ME slot state.
//   - Bus width constants. The data-independent parts are EXB_CTRL_W and WBB_CTRL_W.
//     The full bus widths are these plus DATA_W.
//     ex_bus       = {excp_en, excp_num[6:0], is_mem, is_load, ld_op[2:0],
//                     gr_we, dest[4:0], pc[31:0], result[DATA_W-1:0]}
//     me_to_wb_bus = {excp_en, excp_num[6:0], pc[31:0], gr_we, dest[4:0],
//                     final_result[DATA_W-1:0]}
//   - CNT_W: width of the outstanding and discard counters (depth up to 7).
package me_mem_stage_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_D  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] LD_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } me_state_e;

  localparam int EXB_CTRL_W = 1 + 7 + 1 + 1 + 3 + 1 + 5 + 32;
  localparam int WBB_CTRL_W = 1 + 7 + 32 + 1 + 5;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/me_load_align.sv
// me_load_align -- combinational load data alignment and extension.
//
// Ports:
//   ld_op   in   3       load size/sign selector (see me_mem_stage_pkg)
//   addr_lo in   LANE_W  low address bits selecting the byte lane
//   rdata   in   DATA_W  raw data-SRAM word
//   data    out  DATA_W  aligned, zero/sign extended load value
//
// Accesses are assumed naturally aligned. A doubleword op on a 32-bit datapath
// degenerates to a full-word load.
module me_load_align
  import me_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = (DATA_W == 64) ? 3 : 2
) (
  input  logic [2:0]        ld_op,
  input  logic [LANE_W-1:0] addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;
  logic              fill;
  int                width;

  always_comb begin
    // Bring the addressed lane down to bit 0, then extend above the access width.
    shifted = rdata >> {addr_lo, 3'b000};
    case (ld_op[1:0])
      2'b00: begin
        width = 8;
        fill  = shifted[7];
      end
      2'b01: begin
        width = 16;
        fill  = shifted[15];
      end
      2'b10: begin
        width = 32;
        fill  = shifted[31];
      end
      default: begin
        width = DATA_W;
        fill  = shifted[DATA_W-1];
      end
    endcase
    if (ld_op[2]) fill = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = (i < width) ? shifted[i] : fill;
    end
  end

endmodule

// File: rtl/me_mem_stage.sv
// me_mem_stage -- one-entry memory pipeline stage between EX and WB.
//
// The entry is EMPTY, WAIT, or READY:
//   - WAIT: a memory op is waiting for its data-SRAM response.
//   - READY: the result is available for WB.
// Outstanding data-SRAM requests are counted so that EX can be throttled.
// After a flush, responses already in flight are counted into a discard
// counter. They are then swallowed without touching the entry.
//
// Handshakes:
//   - ex_valid / me_allow_in: one instruction moves EX->ME on a cycle when both
//     are high. me_allow_in is high when the slot is empty, or when it is READY
//     and WB takes it the same cycle.
//   - me_to_wb_valid / wb_allow_in: the result moves ME->WB when both are high.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   ex_valid, ex_bus     instruction from EX
//   me_allow_in          ME accepts ex_bus this cycle
//   req_accept           EX completed a data-SRAM request this cycle
//   mem_req_allow        EX may issue a new data-SRAM request
//   data_ok, rdata       data-SRAM response
//   flush                exception/ertn flush; has priority over everything
//   wb_allow_in          WB accepts
//   me_to_wb_valid/_bus  result towards WB
//   me_dest              destination register for hazard checks (0 if none)
//   me_fwd_data          forwarded final result
//   me_fwd_pending       load still waiting for data; ID must stall
//   me_sys_op            entry carries an exception
//   perf_wait_cnt        WAIT-cycle counter; present only with ME_PERF_CNT_EN defined
module me_mem_stage
  import me_mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OUTST_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ex_valid,
  input  logic [EXB_CTRL_W+DATA_W-1:0] ex_bus,
  output logic                         me_allow_in,
  input  logic                         req_accept,
  output logic                         mem_req_allow,
  input  logic                         data_ok,
  input  logic [DATA_W-1:0]            rdata,
  input  logic                         flush,
  input  logic                         wb_allow_in,
  output logic                         me_to_wb_valid,
  output logic [WBB_CTRL_W+DATA_W-1:0] me_to_wb_bus,
  output logic [4:0]                   me_dest,
  output logic [DATA_W-1:0]            me_fwd_data,
  output logic                         me_fwd_pending,
  output logic                         me_sys_op
`ifdef ME_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_wait_cnt
`endif
);

  localparam int LANE_W = (DATA_W == 64) ? 3 : 2;

  // Unpacked view of the incoming EX bus.
  logic              ex_excp_en;
  logic [6:0]        ex_excp_num;
  logic              ex_is_mem;
  logic              ex_is_load;
  logic [2:0]        ex_ld_op;
  logic              ex_gr_we;
  logic [4:0]        ex_dest;
  logic [31:0]       ex_pc;
  logic [DATA_W-1:0] ex_result;

  assign {ex_excp_en, ex_excp_num, ex_is_mem, ex_is_load, ex_ld_op,
          ex_gr_we, ex_dest, ex_pc, ex_result} = ex_bus;

  // Entry registers; is_mem is only needed at capture time.
  logic              e_excp_en;
  logic [6:0]        e_excp_num;
  logic              e_is_load;
  logic [2:0]        e_ld_op;
  logic              e_gr_we;
  logic [4:0]        e_dest;
  logic [31:0]       e_pc;
  logic [DATA_W-1:0] e_result;
  logic [DATA_W-1:0] hold_q;

  me_state_e         state_q, state_d;
  logic [CNT_W-1:0]  outst_q, outst_next;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic              capture;
  logic              hold_we;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;
  logic              entry_valid;

  // Outstanding request count; a request and a response in the same cycle cancel.
  always_comb begin
    outst_next = outst_q;
    if (req_accept && !data_ok) begin
      outst_next = outst_q + CNT_W'(1);
    end else if (!req_accept && data_ok && (outst_q != '0)) begin
      outst_next = outst_q - CNT_W'(1);
    end
  end

  assign me_allow_in   = (state_q == ST_EMPTY) || ((state_q == ST_READY) && wb_allow_in);
  assign mem_req_allow = (int'(outst_q) < OUTST_DEPTH) && !flush;

  // Next-state logic. Flush wins. Otherwise, a response is either swallowed
  // (discard pending) or completes a waiting entry, and then the slot is refilled or drained.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    capture   = 1'b0;
    hold_we   = 1'b0;
    if (flush) begin
      state_d   = ST_EMPTY;
      // Every request still unanswered after this cycle belongs to flushed work.
      discard_d = outst_next;
    end else begin
      if (data_ok) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else if (state_q == ST_WAIT) begin
          state_d = ST_READY;
          hold_we = 1'b1;
        end
      end
      if (ex_valid && me_allow_in) begin
        capture = 1'b1;
        state_d = (ex_is_mem && !ex_excp_en) ? ST_WAIT : ST_READY;
      end else if ((state_q == ST_READY) && wb_allow_in) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_EMPTY;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_next;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_excp_en  <= 1'b0;
      e_excp_num <= '0;
      e_is_load  <= 1'b0;
      e_ld_op    <= '0;
      e_gr_we    <= 1'b0;
      e_dest     <= '0;
      e_pc       <= '0;
      e_result   <= '0;
      hold_q     <= '0;
    end else begin
      if (capture) begin
        e_excp_en  <= ex_excp_en;
        e_excp_num <= ex_excp_num;
        e_is_load  <= ex_is_load;
        e_ld_op    <= ex_ld_op;
        e_gr_we    <= ex_gr_we;
        e_dest     <= ex_dest;
        e_pc       <= ex_pc;
        e_result   <= ex_result;
      end
      if (hold_we) begin
        hold_q <= rdata;
      end
    end
  end

  me_load_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_load_align (
    .ld_op   (e_ld_op),
    .addr_lo (e_result[LANE_W-1:0]),
    .rdata   (hold_q),
    .data    (load_data)
  );

  assign final_result   = (e_is_load && !e_excp_en) ? load_data : e_result;
  assign entry_valid    = (state_q != ST_EMPTY);
  assign me_to_wb_valid = (state_q == ST_READY);
  assign me_to_wb_bus   = {e_excp_en, e_excp_num, e_pc, e_gr_we, e_dest, final_result};
  assign me_dest        = (entry_valid && e_gr_we) ? e_dest : 5'd0;
  assign me_fwd_data    = final_result;
  assign me_fwd_pending = (state_q == ST_WAIT) && e_is_load;
  assign me_sys_op      = entry_valid && e_excp_en;

`ifdef ME_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_wait_cnt <= '0;
    end else if (state_q == ST_WAIT) begin
      perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the SRAM side broke protocol.
  a_no_orphan_data_ok : assert property (
    @(posedge clk) disable iff (!resetn) data_ok |-> (outst_q != '0));
`endif

endmodule

// File: tb/tb_me_mem_stage.sv
module tb_me_mem_stage;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int EXB_W  = 51 + DATA_W;
  localparam int WBB_W  = 46 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              ex_valid, req_accept, data_ok, flush, wb_allow_in;
  logic [DATA_W-1:0] rdata;
  logic [EXB_W-1:0]  ex_bus;
  logic              me_allow_in, mem_req_allow, me_to_wb_valid;
  logic [WBB_W-1:0]  me_to_wb_bus;
  logic [4:0]        me_dest;
  logic [DATA_W-1:0] me_fwd_data;
  logic              me_fwd_pending, me_sys_op;

  logic              i_excp_en, i_is_mem, i_is_load, i_gr_we;
  logic [6:0]        i_excp_num;
  logic [2:0]        i_ld_op;
  logic [4:0]        i_dest;
  logic [31:0]       i_pc;
  logic [DATA_W-1:0] i_result;

  assign ex_bus = {i_excp_en, i_excp_num, i_is_mem, i_is_load, i_ld_op,
                   i_gr_we, i_dest, i_pc, i_result};

  me_mem_stage #(.DATA_W(DATA_W), .OUTST_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_valid       (ex_valid),
    .ex_bus         (ex_bus),
    .me_allow_in    (me_allow_in),
    .req_accept     (req_accept),
    .mem_req_allow  (mem_req_allow),
    .data_ok        (data_ok),
    .rdata          (rdata),
    .flush          (flush),
    .wb_allow_in    (wb_allow_in),
    .me_to_wb_valid (me_to_wb_valid),
    .me_to_wb_bus   (me_to_wb_bus),
    .me_dest        (me_dest),
    .me_fwd_data    (me_fwd_data),
    .me_fwd_pending (me_fwd_pending),
    .me_sys_op      (me_sys_op)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  // One flag per in-flight request, oldest first: 1 = belongs to flushed work.
  bit          resp_q[$];
  bit          m_full, m_ready;
  logic        m_excp_en, m_is_load, m_gr_we;
  logic [6:0]  m_excp_num;
  logic [2:0]  m_ld_op;
  logic [4:0]  m_dest;
  logic [31:0] m_pc, m_result, m_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * addr[1:0]);
    case (op)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] exp_final();
    return (m_is_load && !m_excp_en) ? exp_load(m_ld_op, m_result, m_rdata) : m_result;
  endfunction

  task automatic model_reset();
    resp_q.delete();
    m_full  = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic model_edge(input bit allow);
    bit pre_wait, pre_ready, stale;
    pre_wait  = m_full && !m_ready;
    pre_ready = m_full && m_ready;
    stale     = 1'b0;
    if (data_ok) stale = resp_q.pop_front();
    if (req_accept) resp_q.push_back(1'b0);
    if (flush) begin
      foreach (resp_q[k]) resp_q[k] = 1'b1;
      m_full = 1'b0;
    end else begin
      if (data_ok && !stale && pre_wait) begin
        m_ready = 1'b1;
        m_rdata = rdata;
      end
      if (ex_valid && allow) begin
        m_full = 1'b1; m_ready = !(i_is_mem && !i_excp_en);
        m_excp_en = i_excp_en; m_excp_num = i_excp_num; m_is_load = i_is_load;
        m_ld_op = i_ld_op; m_gr_we = i_gr_we; m_dest = i_dest; m_pc = i_pc;
        m_result = i_result;
      end else if (pre_ready && wb_allow_in) begin
        m_full = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ex(input logic ee, input logic im, input logic il, input logic [2:0] op,
                        input logic gw, input logic [4:0] d, input logic [31:0] res);
    ex_valid = 1'b1;
    i_excp_en = ee; i_is_mem = im; i_is_load = il; i_ld_op = op;
    i_gr_we = gw; i_dest = d; i_result = res;
    i_excp_num = 7'($urandom);
    i_pc = $urandom;
  endtask

  // One clock: compare outputs against the model mid-cycle, advance the model
  // at the edge, then clear single-cycle pulses.
  task automatic step();
    bit exp_allow;
    @(negedge clk);
    exp_allow = !m_full || (m_ready && wb_allow_in);
    chk("me_allow_in", 128'(me_allow_in), 128'(exp_allow));
    chk("mem_req_allow", 128'(mem_req_allow), 128'((resp_q.size() < DEPTH) && !flush));
    chk("me_to_wb_valid", 128'(me_to_wb_valid), 128'(m_full && m_ready));
    chk("me_dest", 128'(me_dest), 128'((m_full && m_gr_we) ? m_dest : 5'd0));
    chk("me_fwd_pending", 128'(me_fwd_pending), 128'(m_full && !m_ready && m_is_load));
    chk("me_sys_op", 128'(me_sys_op), 128'(m_full && m_excp_en));
    if (m_full && m_ready) begin
      chk("me_to_wb_bus", 128'(me_to_wb_bus),
          128'({m_excp_en, m_excp_num, m_pc, m_gr_we, m_dest, exp_final()}));
      chk("me_fwd_data", 128'(me_fwd_data), 128'(exp_final()));
    end
    model_edge(exp_allow);
    @(posedge clk);
    #1;
    ex_valid = 1'b0; req_accept = 1'b0; data_ok = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst me_allow_in", 128'(me_allow_in), 128'(1'b1));
    chk("rst mem_req_allow", 128'(mem_req_allow), 128'(1'b1));
    chk("rst me_to_wb_valid", 128'(me_to_wb_valid), 128'(1'b0));
    chk("rst me_to_wb_bus", 128'(me_to_wb_bus), 128'(0));
    chk("rst me_dest", 128'(me_dest), 128'(0));
    chk("rst me_fwd_data", 128'(me_fwd_data), 128'(0));
    chk("rst me_fwd_pending", 128'(me_fwd_pending), 128'(1'b0));
    chk("rst me_sys_op", 128'(me_sys_op), 128'(1'b0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    int          r;

    resetn = 1'b0; ex_valid = 1'b0; req_accept = 1'b0; data_ok = 1'b0;
    flush = 1'b0; wb_allow_in = 1'b1; rdata = '0;
    i_excp_en = 0; i_excp_num = 0; i_is_mem = 0; i_is_load = 0; i_ld_op = 0;
    i_gr_we = 0; i_dest = 0; i_pc = 0; i_result = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    resetn = 1'b1;
    step();

    // ld.b from byte 3: 0x80 sign-extends.
    set_ex(0, 1, 1, 3'b000, 1, 5'd7, 32'h1003);
    req_accept = 1'b1;
    step();
    data_ok = 1'b1; rdata = 32'h80FF_0000;
    step();
    chk("ld.b value", 128'(me_fwd_data), 128'(32'hFFFF_FF80));
    step();

    // ld.hu from the upper half: zero-extended.
    set_ex(0, 1, 1, 3'b101, 1, 5'd8, 32'h1002);
    req_accept = 1'b1;
    step();
    data_ok = 1'b1; rdata = 32'h80FF_0000;
    step();
    chk("ld.hu value", 128'(me_fwd_data), 128'(32'h0000_80FF));
    step();

    // Response three cycles after capture: pending for 3 cycles, valid on the 4th.
    set_ex(0, 1, 1, 3'b010, 1, 5'd9, 32'h2000);
    req_accept = 1'b1;
    step();
    for (int c = 1; c <= 3; c++) begin
      chk("pending while waiting", 128'(me_fwd_pending), 128'(1'b1));
      chk("no wb_valid while waiting", 128'(me_to_wb_valid), 128'(1'b0));
      if (c == 3) begin
        data_ok = 1'b1; rdata = 32'hCAFE_F00D;
      end
      step();
    end
    chk("wb_valid after data", 128'(me_to_wb_valid), 128'(1'b1));
    chk("pending cleared", 128'(me_fwd_pending), 128'(1'b0));
    step();

    // Two requests in flight, flush, both responses swallowed, then a fresh load.
    set_ex(0, 1, 1, 3'b010, 1, 5'd10, 32'h3000);
    req_accept = 1'b1;
    step();
    req_accept = 1'b1;
    step();
    chk("req blocked at depth", 128'(mem_req_allow), 128'(1'b0));
    flush = 1'b1;
    step();
    chk("empty after flush", 128'(me_allow_in), 128'(1'b1));
    for (int c = 0; c < 2; c++) begin
      data_ok = 1'b1; rdata = $urandom;
      step();
      chk("discarded data_ok", 128'(me_to_wb_valid), 128'(1'b0));
    end
    chk("req allowed after drain", 128'(mem_req_allow), 128'(1'b1));
    set_ex(0, 1, 1, 3'b010, 1, 5'd11, 32'h3004);
    req_accept = 1'b1;
    step();
    data_ok = 1'b1; rdata = 32'h1234_5678;
    step();
    chk("post-flush load valid", 128'(me_to_wb_valid), 128'(1'b1));
    chk("post-flush load data", 128'(me_fwd_data), 128'(32'h1234_5678));
    step();

    // At depth, a simultaneous request and response keep the count at 2.
    set_ex(0, 1, 1, 3'b010, 1, 5'd12, 32'h4000);
    req_accept = 1'b1;
    step();
    req_accept = 1'b1;
    step();
    chk("full: mem_req_allow", 128'(mem_req_allow), 128'(1'b0));
    req_accept = 1'b1; data_ok = 1'b1; rdata = 32'h0BAD_BEEF;
    step();
    chk("count stays 2", 128'(mem_req_allow), 128'(1'b0));
    step();
    data_ok = 1'b1;
    step();
    chk("count 1 after drain", 128'(mem_req_allow), 128'(1'b1));
    data_ok = 1'b1;
    step();

    // WB back-pressure: the result is held and ME refuses new work.
    wb_allow_in = 1'b0;
    set_ex(0, 1, 1, 3'b000, 1, 5'd13, 32'h5001);
    req_accept = 1'b1;
    step();
    data_ok = 1'b1; rdata = 32'h0000_7F00;
    step();
    for (int c = 0; c < 3; c++) begin
      chk("held wb_valid", 128'(me_to_wb_valid), 128'(1'b1));
      chk("held allow_in", 128'(me_allow_in), 128'(1'b0));
      chk("held data", 128'(me_fwd_data), 128'(32'h0000_007F));
      step();
    end
    wb_allow_in = 1'b1;
    #1;
    chk("release allow_in", 128'(me_allow_in), 128'(1'b1));
    step();
    chk("delivered", 128'(me_to_wb_valid), 128'(1'b0));

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      wb_allow_in = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 4);
        op = (r < 3) ? 3'(r) : 3'(r + 1);
        addr = $urandom & 32'hFFFF_FFFC;
        if (op[1:0] == 2'b00) addr[1:0] = 2'($urandom_range(0, 3));
        else if (op[1:0] == 2'b01) addr[1] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0: set_ex($urandom_range(0, 7) == 0, 0, 0, 3'($urandom), 1'($urandom), 5'($urandom), $urandom);
          1: set_ex($urandom_range(0, 7) == 0, 1, 1, op, 1'($urandom), 5'($urandom), addr);
          default: set_ex($urandom_range(0, 7) == 0, 1, 0, 3'($urandom), 0, 5'($urandom), addr);
        endcase
      end
      req_accept = (resp_q.size() < DEPTH) && !flush && ($urandom_range(0, 1) == 1);
      data_ok = (resp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      rdata = $urandom;
      step();
    end
    // Let anything still in flight drain before the reset test.
    while (resp_q.size() > 0) begin
      data_ok = 1'b1; rdata = $urandom;
      step();
    end
    wb_allow_in = 1'b1;
    step();
    step();

    // Reset asserted while a load waits: everything clears.
    set_ex(0, 1, 1, 3'b010, 1, 5'd14, 32'h6000);
    req_accept = 1'b1;
    step();
    chk("pending before reset", 128'(me_fwd_pending), 128'(1'b1));
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
